// File: rtl/ale_stream_pkg.sv
// rtl/ale_stream_pkg.sv - shared defaults, counter width and reciprocal helper for ale_stream
package ale_stream_pkg;

  localparam int ALE_DATA_W     = 8;
  localparam int ALE_NUM_CH     = 3;
  localparam int ALE_WIN_PIX    = 9;
  localparam int ALE_IMG_W      = 512;
  localparam int ALE_IMG_H      = 512;
  localparam int ALE_RECIP_W    = 10;
  localparam int ALE_RECIP_FRAC = 14;
  localparam int ALE_TIE_LAST   = 0;

  // A 1x1 image still needs a one-bit counter.
  function automatic int ale_cnt_w(input int img_w, input int img_h);
    int n;
    n = img_w * img_h;
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // round-half-up of 2^frac / x, saturated to the output width; x = 0 saturates.
  function automatic longint unsigned ale_recip(input longint unsigned x,
                                                input int recip_w,
                                                input int recip_frac);
    longint unsigned num;
    longint unsigned q;
    longint unsigned maxv;
    maxv = (64'd1 << recip_w) - 64'd1;
    if (x == 64'd0) return maxv;
    num = 64'd1 << recip_frac;
    q = ((num << 1) + x) / (x << 1);
    return (q > maxv) ? maxv : q;
  endfunction

endpackage

// File: rtl/ale_recip_lut.sv
// rtl/ale_recip_lut.sv - combinational reciprocal ROM, one entry per channel code
module ale_recip_lut
  import ale_stream_pkg::*;
#(
  parameter int DATA_W     = ALE_DATA_W,
  parameter int RECIP_W    = ALE_RECIP_W,
  parameter int RECIP_FRAC = ALE_RECIP_FRAC
) (
  input  logic [DATA_W-1:0]  addr_i,
  output logic [RECIP_W-1:0] data_o
);

  logic [RECIP_W-1:0] rom [2**DATA_W];

  for (genvar i = 0; i < 2**DATA_W; i++) begin : g_rom
    assign rom[i] = RECIP_W'(ale_recip(64'(i), RECIP_W, RECIP_FRAC));
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/ale_stream.sv
// rtl/ale_stream.sv - per-frame atmospheric light estimator over a window stream
module ale_stream
  import ale_stream_pkg::*;
#(
  parameter int DATA_W     = ALE_DATA_W,
  parameter int NUM_CH     = ALE_NUM_CH,
  parameter int WIN_PIX    = ALE_WIN_PIX,
  parameter int IMG_W      = ALE_IMG_W,
  parameter int IMG_H      = ALE_IMG_H,
  parameter int RECIP_W    = ALE_RECIP_W,
  parameter int RECIP_FRAC = ALE_RECIP_FRAC,
  parameter int TIE_LAST   = ALE_TIE_LAST
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_sof,
  input  logic [WIN_PIX*NUM_CH*DATA_W-1:0]   in_window,
  output logic [NUM_CH*DATA_W-1:0]           a_light,
  output logic [NUM_CH*RECIP_W-1:0]          a_inv,
  output logic                               a_valid,
  output logic [15:0]                        frame_cnt
);

  localparam int PIX_W = NUM_CH * DATA_W;
  localparam int CNT_W = ale_cnt_w(IMG_W, IMG_H);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [RECIP_W-1:0] INV_RST =
    RECIP_W'(ale_recip(64'(2**DATA_W - 1), RECIP_W, RECIP_FRAC));

  logic [CNT_W-1:0]        cnt_q, cnt_d, idx;
  logic                    is_last;
  logic [PIX_W-1:0]        win_min;

  logic                    s1_valid_q, s1_first_q, s1_last_q;
  logic [PIX_W-1:0]        s1_min_q;
  logic [DATA_W-1:0]       dark_d;

  logic                    s2_valid_q, s2_first_q, s2_last_q;
  logic [PIX_W-1:0]        s2_min_q;
  logic [DATA_W-1:0]       s2_dark_q;

  logic [DATA_W-1:0]       run_dark_q;
  logic [PIX_W-1:0]        run_min_q;
  logic                    run_load;
  logic                    done_q;

  logic [NUM_CH*RECIP_W-1:0] inv_d;
  logic [PIX_W-1:0]          a_light_q;
  logic [NUM_CH*RECIP_W-1:0] a_inv_q;
  logic                      a_valid_q;
  logic [15:0]               frame_cnt_q;

  // An sof beat is index 0 wherever the counter was; the partial frame never reaches LAST_IDX.
  always_comb begin
    idx     = in_sof ? '0 : cnt_q;
    is_last = (idx == LAST_IDX);
    cnt_d   = cnt_q;
    if (in_valid) cnt_d = is_last ? '0 : idx + CNT_W'(1);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] m;
    always_comb begin
      m = in_window[((WIN_PIX-1)*NUM_CH + (NUM_CH-1-c))*DATA_W +: DATA_W];
      for (int p = 1; p < WIN_PIX; p++) begin
        if (in_window[((WIN_PIX-1-p)*NUM_CH + (NUM_CH-1-c))*DATA_W +: DATA_W] < m)
          m = in_window[((WIN_PIX-1-p)*NUM_CH + (NUM_CH-1-c))*DATA_W +: DATA_W];
      end
    end
    assign win_min[(NUM_CH-1-c)*DATA_W +: DATA_W] = m;
  end

  always_comb begin
    dark_d = s1_min_q[PIX_W-1 -: DATA_W];
    for (int c = 1; c < NUM_CH; c++) begin
      if (s1_min_q[(NUM_CH-1-c)*DATA_W +: DATA_W] < dark_d)
        dark_d = s1_min_q[(NUM_CH-1-c)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    run_load = 1'b0;
    if (s2_valid_q) begin
      if (s2_first_q)         run_load = 1'b1;
      else if (TIE_LAST != 0) run_load = (s2_dark_q >= run_dark_q);
      else                    run_load = (s2_dark_q > run_dark_q);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lut
    ale_recip_lut #(
      .DATA_W     (DATA_W),
      .RECIP_W    (RECIP_W),
      .RECIP_FRAC (RECIP_FRAC)
    ) u_lut (
      .addr_i (run_min_q[(NUM_CH-1-c)*DATA_W +: DATA_W]),
      .data_o (inv_d[(NUM_CH-1-c)*RECIP_W +: RECIP_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      run_dark_q  <= '0;
      run_min_q   <= '1;
      a_light_q   <= '1;
      a_inv_q     <= {NUM_CH{INV_RST}};
      a_valid_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      if (run_load) begin
        run_dark_q <= s2_dark_q;
        run_min_q  <= s2_min_q;
      end
      // done_q lags the run update by one edge so the output reads the final run_min.
      done_q    <= s2_valid_q & s2_last_q;
      a_valid_q <= done_q;
      if (done_q) begin
        a_light_q   <= run_min_q;
        a_inv_q     <= inv_d;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_first_q <= (idx == '0);
    s1_last_q  <= is_last;
    s1_min_q   <= win_min;
    s2_first_q <= s1_first_q;
    s2_last_q  <= s1_last_q;
    s2_min_q   <= s1_min_q;
    s2_dark_q  <= dark_d;
  end

  assign a_light   = a_light_q;
  assign a_inv     = a_inv_q;
  assign a_valid   = a_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ale_stream.sv
// tb/tb_ale_stream.sv - self-checking bench for ale_stream with a frame-level reference model
module tb_ale_stream;

  localparam int PW = 24;
  localparam int WP = 9;
  localparam int WW = WP * PW;
  localparam int NB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [WW-1:0] in_window = '0;

  logic [23:0] al0, al1;
  logic [29:0] ai0, ai1;
  logic        av0, av1;
  logic [15:0] fc0, fc1;

  always #5 clk = ~clk;

  ale_stream #(.IMG_W(4), .IMG_H(4), .TIE_LAST(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_window(in_window),
    .a_light(al0), .a_inv(ai0), .a_valid(av0), .frame_cnt(fc0)
  );

  ale_stream #(.IMG_W(4), .IMG_H(4), .TIE_LAST(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_window(in_window),
    .a_light(al1), .a_inv(ai1), .a_valid(av1), .frame_cnt(fc1)
  );

  typedef struct packed {
    logic [23:0] al;
    logic [29:0] ai;
    logic [15:0] fc;
  } res_t;

  res_t got0[$], got1[$], exp0[$], exp1[$];
  int   compared = 0;
  int   mismatched = 0;
  logic [15:0] exp_fc = '0;
  logic [PW-1:0] fr [NB][WP];

  always @(negedge clk) begin
    if (av0) got0.push_back({al0, ai0, fc0});
    if (av1) got1.push_back({al1, ai1, fc1});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_recip(input logic [7:0] x);
    int q, r;
    if (x == 8'd0) return 10'd1023;
    q = 16384 / int'(x);
    r = 16384 % int'(x);
    if (2 * r >= int'(x)) q++;
    if (q > 1023) q = 1023;
    return 10'(q);
  endfunction

  function automatic logic [WW-1:0] pack_win(input int b);
    logic [WW-1:0] w;
    for (int p = 0; p < WP; p++) w[(WP-1-p)*PW +: PW] = fr[b][p];
    return w;
  endfunction

  function automatic logic [23:0] win_min(input int b);
    logic [23:0] m;
    logic [7:0]  v;
    m = 24'hFFFFFF;
    for (int ch = 0; ch < 3; ch++)
      for (int p = 0; p < WP; p++) begin
        v = fr[b][p][(2-ch)*8 +: 8];
        if (v < m[(2-ch)*8 +: 8]) m[(2-ch)*8 +: 8] = v;
      end
    return m;
  endfunction

  function automatic logic [7:0] dark_of(input logic [23:0] m);
    logic [7:0] d;
    d = m[23:16];
    if (m[15:8] < d) d = m[15:8];
    if (m[7:0] < d) d = m[7:0];
    return d;
  endfunction

  // Brightest dark channel over the frame, then the first or last window reaching it.
  function automatic res_t model(input bit tie_last, input logic [15:0] fc);
    logic [7:0]  best;
    int          pick;
    logic [23:0] a;
    res_t        r;
    best = 8'd0;
    for (int b = 0; b < NB; b++) if (dark_of(win_min(b)) > best) best = dark_of(win_min(b));
    pick = -1;
    for (int b = 0; b < NB; b++)
      if (dark_of(win_min(b)) == best && (tie_last || pick < 0)) pick = b;
    a = win_min(pick);
    r.al = a;
    r.ai = {ref_recip(a[23:16]), ref_recip(a[15:8]), ref_recip(a[7:0])};
    r.fc = fc;
    return r;
  endfunction

  task automatic set_beat(input int b, input logic [23:0] v);
    for (int p = 0; p < WP; p++) fr[b][p] = v;
  endtask

  task automatic fill_const(input logic [23:0] v);
    for (int b = 0; b < NB; b++) set_beat(b, v);
  endtask

  // Each window gets a per-channel floor on a coarse grid so ties across windows are common.
  task automatic fill_rand();
    logic [7:0] base [3];
    for (int b = 0; b < NB; b++) begin
      for (int ch = 0; ch < 3; ch++) base[ch] = 8'($urandom_range(0, 7) * 32 + 16);
      for (int p = 0; p < WP; p++)
        for (int ch = 0; ch < 3; ch++)
          fr[b][p][(2-ch)*8 +: 8] = (p == int'($urandom_range(0, WP - 1)) || p == 0) ? base[ch]
                                    : 8'(int'(base[ch]) + int'($urandom_range(0, 255 - int'(base[ch]))));
    end
  endtask

  task automatic beat(input logic [WW-1:0] w, input logic sof);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof = sof;
    in_window = w;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'($urandom);
      in_window = {7{$urandom}};
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic first_sof, input int gap_max);
    for (int b = 0; b < NB; b++) begin
      beat(pack_win(b), (b == 0) ? first_sof : 1'b0);
      if (gap_max > 0 && b != NB - 1) idle($urandom_range(0, gap_max));
    end
    exp_fc = exp_fc + 16'd1;
    exp0.push_back(model(1'b0, exp_fc));
    exp1.push_back(model(1'b1, exp_fc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    exp_fc = '0;
  endtask

  task automatic check_logs(input string tag);
    res_t e, g;
    chk({tag, " pulses0"}, 64'(got0.size()), 64'(exp0.size()));
    chk({tag, " pulses1"}, 64'(got1.size()), 64'(exp1.size()));
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      g = (got0.size() > 0) ? got0.pop_front() : '0;
      chk({tag, " t0 a_light"}, 64'(g.al), 64'(e.al));
      chk({tag, " t0 a_inv"}, 64'(g.ai), 64'(e.ai));
      chk({tag, " t0 frame_cnt"}, 64'(g.fc), 64'(e.fc));
    end
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      g = (got1.size() > 0) ? got1.pop_front() : '0;
      chk({tag, " t1 a_light"}, 64'(g.al), 64'(e.al));
      chk({tag, " t1 a_inv"}, 64'(g.ai), 64'(e.ai));
      chk({tag, " t1 frame_cnt"}, 64'(g.fc), 64'(e.fc));
    end
    got0.delete();
    got1.delete();
  endtask

  initial begin
    do_reset();
    idle(3);
    chk("reset a_light", 64'(al0), 64'(24'hFFFFFF));
    chk("reset a_inv", 64'(ai0), 64'({10'd64, 10'd64, 10'd64}));
    chk("reset a_valid", 64'(av0), 64'd0);
    chk("reset frame_cnt", 64'(fc0), 64'd0);
    chk("reset a_light t1", 64'(al1), 64'(24'hFFFFFF));

    fill_const(24'h101010);
    set_beat(7, 24'h80A0C0);
    send_frame(1'b1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
    chk("lat edge+1", 64'(av0), 64'd0);
    @(negedge clk);
    chk("lat edge+2", 64'(av0), 64'd0);
    @(negedge clk);
    chk("lat edge+3 early", 64'(av0), 64'd0);
    @(negedge clk);
    chk("lat pulse", 64'(av0), 64'd1);
    chk("bright a_light", 64'(al0), 64'(24'h80A0C0));
    chk("bright a_inv", 64'(ai0), 64'({10'd128, 10'd102, 10'd85}));
    chk("bright frame_cnt", 64'(fc0), 64'd1);
    @(negedge clk);
    chk("pulse width", 64'(av0), 64'd0);
    idle(4);
    chk("hold a_light", 64'(al0), 64'(24'h80A0C0));
    check_logs("bright");

    fill_const(24'h101010);
    set_beat(3, 24'h50FF60);
    set_beat(9, 24'h609050);
    send_frame(1'b1, 0);
    idle(6);
    chk("tie first", 64'(al0), 64'(24'h50FF60));
    chk("tie last", 64'(al1), 64'(24'h609050));
    check_logs("tie");

    do_reset();
    fill_const(24'h000000);
    send_frame(1'b1, 0);
    fill_rand();
    send_frame(1'b1, 0);
    idle(6);
    chk("zero a_light", 64'((got0.size() > 0) ? got0[0].al : 24'h5A5A5A), 64'd0);
    chk("zero a_inv", 64'((got0.size() > 0) ? got0[0].ai : 30'd0), 64'({10'd1023, 10'd1023, 10'd1023}));
    chk("b2b frame_cnt", 64'(fc0), 64'd2);
    check_logs("b2b");

    fill_const(24'hFAFAFA);
    for (int b = 0; b < 6; b++) beat(pack_win(b), (b == 0) ? 1'b1 : 1'b0);
    fill_rand();
    send_frame(1'b1, 0);
    idle(6);
    chk("midsof frame_cnt", 64'(fc0), 64'd3);
    check_logs("midsof");

    fill_const(24'h202020);
    set_beat(2, 24'hFFFFFF);
    for (int b = 0; b < 5; b++) beat(pack_win(b), (b == 0) ? 1'b1 : 1'b0);
    do_reset();
    idle(4);
    chk("rst a_light", 64'(al0), 64'(24'hFFFFFF));
    chk("rst a_inv", 64'(ai0), 64'({10'd64, 10'd64, 10'd64}));
    chk("rst frame_cnt", 64'(fc0), 64'd0);
    chk("rst a_valid", 64'(av0), 64'd0);
    fill_rand();
    send_frame(1'b0, 2);
    idle(6);
    chk("post-rst frame_cnt", 64'(fc1), 64'd1);
    check_logs("postrst");

    for (int f = 0; f < 8; f++) begin
      fill_rand();
      send_frame(1'b1, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
    idle(6);
    check_logs("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
